sevenseg_scan: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 29 ++
 rtl/sevenseg_decode.sv | 38 +++
 rtl/sevenseg_scan.sv | 107 ++++++++++
 tb/tb_sevenseg_scan.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and segment patterns for the seven-segment scan driver.
// Hex glyphs for 10..15 exist only when SEVENSEG_HEX_EN is defined.
package sevenseg_pkg;

    typedef logic [3:0] digit_t;

    // Segment order is {a,b,c,d,e,f,g}; a 1 lights the segment.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

`ifdef SEVENSEG_HEX_EN
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
`endif

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational digit-to-segment decoder with a forced-blank input.
// SEVENSEG_HEX_EN selects hex glyphs for 10..15; otherwise they are blank.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  digit_t     value,
    input  logic       blank,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_BLANK;
        if (!blank) begin
            case (value)
                4'd0:    segments = SEG_0;
                4'd1:    segments = SEG_1;
                4'd2:    segments = SEG_2;
                4'd3:    segments = SEG_3;
                4'd4:    segments = SEG_4;
                4'd5:    segments = SEG_5;
                4'd6:    segments = SEG_6;
                4'd7:    segments = SEG_7;
                4'd8:    segments = SEG_8;
                4'd9:    segments = SEG_9;
`ifdef SEVENSEG_HEX_EN
                4'd10:   segments = SEG_A;
                4'd11:   segments = SEG_B;
                4'd12:   segments = SEG_C;
                4'd13:   segments = SEG_D;
                4'd14:   segments = SEG_E;
                4'd15:   segments = SEG_F;
`endif
                default: segments = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment driver with double-buffered load and leading-zero blanking.
// Define SEVENSEG_HEX_EN to display 10..15 as A..F instead of blank.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [6:0]            segments,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);

    logic [DW_W-1:0]     dwell_cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] disp_word;
    logic [4*DIGITS-1:0] pend_word;
    logic                pend_full;

    logic                dwell_wrap_p0;
    logic                boundary_p0;
    logic                accept_p0;
    logic [DIGITS-1:0]   zero_above;
    logic                lz_run;
    logic                zero_sel;
    digit_t              cur_digit;
    logic                cur_blank;
    logic [6:0]          seg_dec;

    assign dwell_wrap_p0 = (dwell_cnt == DW_W'(DWELL - 1));
    assign boundary_p0   = dwell_wrap_p0 && (idx == IDX_W'(DIGITS - 1));
    assign accept_p0     = load_valid && !pend_full;
    assign load_ready    = !pend_full;

    // zero_above[i] is set when digit i and every digit above it are zero.
    always_comb begin
        zero_above = '0;
        lz_run     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_run        = lz_run && (disp_word[4*i +: 4] == 4'd0);
            zero_above[i] = lz_run;
        end
    end

    always_comb begin
        cur_digit = '0;
        zero_sel  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = disp_word[4*i +: 4];
                zero_sel  = zero_above[i];
            end
        end
        cur_blank = blank_lz && (idx != '0) && zero_sel;
    end

    sevenseg_decode u_decode (
        .value    (cur_digit),
        .blank    (cur_blank),
        .segments (seg_dec)
    );

    // p0 -> p1: scan counters, buffer transfer and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_cnt  <= '0;
            idx        <= '0;
            disp_word  <= '0;
            pend_word  <= '0;
            pend_full  <= 1'b0;
            digit_sel  <= '0;
            segments   <= '0;
            frame_done <= 1'b0;
        end else begin
            if (dwell_wrap_p0) begin
                dwell_cnt <= '0;
                idx       <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end

            // A load landing on a boundary with an empty buffer waits one more frame.
            if (boundary_p0 && pend_full) begin
                disp_word <= pend_word;
                pend_full <= 1'b0;
            end else if (accept_p0) begin
                pend_word <= load_data;
                pend_full <= 1'b1;
            end

            frame_done <= boundary_p0;
            digit_sel  <= SEL_ONE << idx;
            segments   <= seg_dec;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan (DIGITS=4, DWELL=4); honours SEVENSEG_HEX_EN.
module tb_sevenseg_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  digit_sel;
    logic [6:0]  segments;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [6:0]  exp_seg_q[$];
    logic [11:0] exp_cyc_q[$];

    always #5 clk = ~clk;

    sevenseg_scan #(.DIGITS(4), .DWELL(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .blank_lz   (blank_lz),
        .digit_sel  (digit_sel),
        .segments   (segments),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] ref_dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'h7E;
            4'd1: return 7'h30;
            4'd2: return 7'h6D;
            4'd3: return 7'h79;
            4'd4: return 7'h33;
            4'd5: return 7'h5B;
            4'd6: return 7'h5F;
            4'd7: return 7'h70;
            4'd8: return 7'h7F;
            4'd9: return 7'h7B;
`ifdef SEVENSEG_HEX_EN
            4'd10: return 7'h77;
            4'd11: return 7'h1F;
            4'd12: return 7'h4E;
            4'd13: return 7'h3D;
            4'd14: return 7'h4F;
            4'd15: return 7'h47;
`endif
            default: return 7'h00;
        endcase
    endfunction

    // Digit i is a leading zero when the word shifted down by i digits is zero.
    function automatic logic [6:0] ref_seg(input logic [15:0] w, input int i, input bit blz);
        if (blz && i > 0 && (w >> (4 * i)) == 16'h0) return 7'h00;
        return ref_dec(w[4*i +: 4]);
    endfunction

    task automatic push_word(input logic [15:0] w, input bit blz);
        for (int i = 0; i < 4; i++) exp_seg_q.push_back(ref_seg(w, i, blz));
    endtask

    // Leaves the bench on the negedge right after release (0 edges since reset).
    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] w);
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = 16'($urandom);
    endtask

    task automatic wait_fd(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            n++;
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called on the negedge where frame_done is high; samples each digit of the next frame.
    task automatic read_frame(output logic [27:0] segs, output logic [15:0] sels);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) @(negedge clk);
            else repeat (4) @(negedge clk);
            segs[7*i +: 7] = segments;
            sels[4*i +: 4] = digit_sel;
        end
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        logic [3:0]  esel;
        do_reset();
        checks++;
        if ({digit_sel, segments, frame_done, load_ready} !== {4'b0, 7'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got sel=%b seg=%h fd=%b rdy=%b want 0000/00/0/1",
                     digit_sel, segments, frame_done, load_ready);
        end
        for (int n = 1; n <= 40; n++) begin
            esel = 4'(1 << (((n - 1) / 4) % 4));
            exp_cyc_q.push_back({esel, 7'h7E, (n % 16) == 0});
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            exp = exp_cyc_q.pop_front();
            checks++;
            if ({digit_sel, segments, frame_done} !== exp) begin
                errors++;
                $display("FAIL scan n=%0d got sel=%b seg=%h fd=%b want sel=%b seg=%h fd=%b",
                         n, digit_sel, segments, frame_done, exp[11:8], exp[7:1], exp[0]);
            end
        end
    endtask

    task automatic test_load_mid_frame();
        logic [27:0] segs;
        logic [15:0] sels;
        logic [6:0]  e;
        bit ok;
        do_reset();
        repeat (5) @(negedge clk);
        push_word(16'h1234, 1'b0);
        load_word(16'h1234);
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_load got %b want 0", load_ready);
        end
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
            checks++;
            if (segments !== 7'h7E) begin
                errors++;
                $display("FAIL hold_old_frame got seg=%h want 7e", segments);
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_done_timeout got none want pulse");
        end
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_transfer got %b want 1", load_ready);
        end
        read_frame(segs, sels);
        for (int i = 0; i < 4; i++) begin
            e = exp_seg_q.pop_front();
            checks++;
            if (segs[7*i +: 7] !== e || sels[4*i +: 4] !== 4'(1 << i)) begin
                errors++;
                $display("FAIL load1234 digit%0d got seg=%h sel=%b want seg=%h sel=%b",
                         i, segs[7*i +: 7], sels[4*i +: 4], e, 4'(1 << i));
            end
        end
    endtask

    task automatic test_blank_lz();
        logic [27:0] segs;
        logic [15:0] sels;
        logic [6:0]  e;
        int n;
        bit ok;
        do_reset();
        blank_lz = 1'b1;
        push_word(16'h0042, 1'b1);
        load_word(16'h0042);
        for (int pass = 0; pass < 2; pass++) begin
            wait_fd(n, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL blank_fd_timeout pass=%0d got none want pulse", pass);
            end
            read_frame(segs, sels);
            for (int i = 0; i < 4; i++) begin
                e = exp_seg_q.pop_front();
                checks++;
                if (segs[7*i +: 7] !== e) begin
                    errors++;
                    $display("FAIL blank_lz=%0d digit%0d got %h want %h", blank_lz, i, segs[7*i +: 7], e);
                end
            end
            blank_lz = 1'b0;
            if (pass == 0) push_word(16'h0042, 1'b0);
        end
    endtask

    task automatic test_ignore_when_busy();
        logic [27:0] segs;
        logic [15:0] sels;
        logic [6:0]  e;
        int n;
        bit ok;
        do_reset();
        repeat (3) @(negedge clk);
        push_word(16'h5678, 1'b0);
        push_word(16'h5678, 1'b0);
        load_word(16'h5678);
        load_valid = 1'b1;
        load_data  = 16'h9999;
        repeat (3) @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready got %b want 0", load_ready);
        end
        for (int pass = 0; pass < 2; pass++) begin
            wait_fd(n, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL busy_fd_timeout pass=%0d got none want pulse", pass);
            end
            read_frame(segs, sels);
            for (int i = 0; i < 4; i++) begin
                e = exp_seg_q.pop_front();
                checks++;
                if (segs[7*i +: 7] !== e) begin
                    errors++;
                    $display("FAIL busy pass=%0d digit%0d got %h want %h", pass, i, segs[7*i +: 7], e);
                end
            end
        end
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_ready_end got %b want 1", load_ready);
        end
    endtask

    task automatic test_hex();
        logic [27:0] segs;
        logic [15:0] sels;
        logic [6:0]  e;
        int n;
        bit ok;
        do_reset();
        push_word(16'h00AF, 1'b0);
        load_word(16'h00AF);
        wait_fd(n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hex_fd_timeout got none want pulse");
        end
        read_frame(segs, sels);
        for (int i = 0; i < 4; i++) begin
            e = exp_seg_q.pop_front();
            checks++;
            if (segs[7*i +: 7] !== e) begin
                errors++;
                $display("FAIL hex digit%0d got %h want %h", i, segs[7*i +: 7], e);
            end
        end
    endtask

    task automatic test_boundary_accept();
        logic [27:0] segs;
        logic [15:0] sels;
        logic [6:0]  e;
        int n;
        bit ok;
        do_reset();
        repeat (15) @(negedge clk);
        push_word(16'h0000, 1'b0);
        push_word(16'h0007, 1'b0);
        load_word(16'h0007);
        checks++;
        if ({frame_done, load_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bnd_accept got fd=%b rdy=%b want fd=1 rdy=0", frame_done, load_ready);
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                wait_fd(n, ok);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL bnd_fd_timeout got none want pulse");
                end
            end
            read_frame(segs, sels);
            for (int i = 0; i < 4; i++) begin
                e = exp_seg_q.pop_front();
                checks++;
                if (segs[7*i +: 7] !== e) begin
                    errors++;
                    $display("FAIL bnd pass=%0d digit%0d got %h want %h", pass, i, segs[7*i +: 7], e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [27:0] segs;
        logic [15:0] sels;
        logic [6:0]  e;
        int n;
        bit ok;
        do_reset();
        load_word(16'h8888);
        wait_fd(n, ok);
        load_word(16'h1234);
        repeat (5) @(negedge clk);
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_pend_full got rdy=%b want 0", load_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({digit_sel, segments, frame_done, load_ready} !== {4'b0, 7'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid got sel=%b seg=%h fd=%b rdy=%b want 0000/00/0/1",
                     digit_sel, segments, frame_done, load_ready);
        end
        reset = 1'b0;
        push_word(16'h0000, 1'b0);
        push_word(16'h0000, 1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            wait_fd(n, ok);
            checks++;
            if (!ok || (pass == 0 && n != 16)) begin
                errors++;
                $display("FAIL rst_fd_latency pass=%0d got ok=%0d n=%0d want ok=1 n=16", pass, ok, n);
            end
            read_frame(segs, sels);
            for (int i = 0; i < 4; i++) begin
                e = exp_seg_q.pop_front();
                checks++;
                if (segs[7*i +: 7] !== e) begin
                    errors++;
                    $display("FAIL rst_disp pass=%0d digit%0d got %h want %h", pass, i, segs[7*i +: 7], e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_mid_frame();
        test_blank_lz();
        test_ignore_when_busy();
        test_hex();
        test_boundary_accept();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
